gray_counter_system_cfg: RTL and testbench
==========================================

// Module: gray_counter_system_cfg
// PURPOSE
//   Parametrised successor of the Gray-counter LED system: an internal prescaler
//   issues a step every DIVIDE enabled clocks, and an N-bit counter advances on each step.
//   Adds up/down counting, a synchronous load, wrap or saturate mode, and run-time
//   selection of Gray or binary LED encoding. Sits between board clock/reset and LEDs.
// PARAMETERS
//   N        4   counter/LED width, >=2
//   DIVIDE   10  enabled clocks per count step, >=1 (1 = step every enabled cycle)
//   SATURATE 0   0: count wraps modulo 2^N; 1: count holds at 0 / 2^N-1
// PORTS
//   clk       in   1  single system clock, all logic on rising edge
//   rst       in   1  synchronous, active-high reset
//   en        in   1  1: prescaler runs; 0: prescaler and count hold
//   dir       in   1  1: count up, 0: count down
//   mode      in   1  0: leds = Gray(cnt), 1: leds = cnt (binary)
//   load      in   1  synchronous load strobe
//   load_val  in   N  binary value loaded into cnt
//   leds      out  N  encoded count
//   tick      out  1  1-cycle pulse, high in the cycle cnt shows a stepped value
//   wrap      out  1  1-cycle pulse, high with tick when that step wrapped
// BEHAVIOUR
//   State: prescaler p (0..DIVIDE-1, width clog2(DIVIDE), min 1); binary count cnt[N-1:0].
//   Reset (rst=1 at edge): p=0, cnt=0, tick=0, wrap=0 -> leds=0. rst beats every input.
//   Priority at each edge: rst > load > step > hold.
//   load=1: cnt<=load_val, p<=0, tick<=0, wrap<=0. Ignores en; cancels a step due that cycle.
//   step = en & ~load & (p==DIVIDE-1): p<=0; cnt<=next; tick<=1; wrap<=wrapped.
//   en=1, no step: p<=p+1, tick<=0, wrap<=0. en=0: p and cnt hold, tick<=0, wrap<=0.
//   next, dir=1: cnt==2^N-1 ? (SATURATE ? cnt : 0) : cnt+1.
//   next, dir=0: cnt==0 ? (SATURATE ? cnt : 2^N-1) : cnt-1.
//   wrapped: 1 only if SATURATE=0 and (up from 2^N-1) or (down from 0).
//   Saturated step: tick still pulses, cnt is unchanged, wrap stays 0.
//   Latency: with en held high from reset release, the first step is on the
//     DIVIDE-th edge; cnt=1 and tick=1 after that edge; steps then every DIVIDE clocks.
//   dir changes apply at the next step; the prescaler phase is not disturbed.
//   en low mid-period freezes p; the period resumes where it left off.
//   leds is combinational from registered cnt and mode:
//     mode=0 -> cnt ^ (cnt>>1); mode=1 -> cnt. A mode change shows in the same cycle
//     and does not alter cnt. Outputs have no combinational path from en/dir/load.
//   Adjacent Gray values differ in exactly 1 bit, including across a wrap.
// TESTING (N=4, DIVIDE=3 unless stated)
//   1 Reset/run: rst 2 cycles, then en=1, dir=1, mode=0 -> tick every 3rd cycle;
//     leds 0,1,3,2,6,...; after 16 ticks cnt=0 with wrap=1 on that tick only.
//   2 Down/wrap: load_val=0, load 1 cycle, then dir=0 -> first tick gives cnt=15,
//     leds=4'b1000, wrap=1.
//   3 Saturate (SATURATE=1): load 14, dir=1 -> cnt 15 then holds at 15;
//     tick keeps pulsing, wrap never 1. Same check at 0 with dir=0.
//   4 Load vs step: assert load (load_val=9) in the cycle p==2 -> cnt=9, tick=0,
//     next tick exactly 3 cycles later gives cnt=10.
//   5 en gap/mode: drop en for 5 cycles at p==1 -> no tick and cnt frozen;
//     resume -> tick 2 cycles later. Toggle mode -> leds switches Gray<->binary
//     with cnt unchanged.
//   6 Reset mid-run with load=1 and DIVIDE=1 -> all outputs 0 next cycle;
//     afterwards tick is high every enabled cycle.
//   All: a scoreboard model checks each cycle that leds changes by 1 bit per tick in Gray mode.

Source files
------------

// File: rtl/gray_counter_system_cfg_if.sv
// rtl/gray_counter_system_cfg_if.sv - control inputs and LED outputs of the Gray counter system
interface gray_counter_system_cfg_if #(
  parameter int N = 4
) ();
  logic         en;
  logic         dir;
  logic         mode;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] leds;
  logic         tick;
  logic         wrap;

  modport master (
    output en, dir, mode, load, load_val,
    input  leds, tick, wrap
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output leds, tick, wrap
  );
endinterface

// File: rtl/gray_counter_system_cfg.sv
// rtl/gray_counter_system_cfg.sv - prescaled up/down counter with load, wrap/saturate and Gray/binary LEDs
module gray_counter_system_cfg #(
  parameter int N        = 4,
  parameter int DIVIDE   = 10,
  parameter bit SATURATE = 1'b0
) (
  input logic                i_clk,
  input logic                i_rst,
  gray_counter_system_cfg_if.slave bus
);
  localparam int PW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIVIDE - 1);
  localparam logic [N-1:0]  CNT_MAX = {N{1'b1}};

  logic [PW-1:0] r_p;
  logic [N-1:0]  r_cnt;
  logic          r_tick;
  logic          r_wrap;

  logic          w_step;
  logic [N-1:0]  w_next;
  logic          w_wrapped;

  assign w_step = bus.en & ~bus.load & (r_p == P_LAST);

  // Boundary values either wrap around or stick, depending on SATURATE.
  always_comb begin
    w_next    = r_cnt;
    w_wrapped = 1'b0;
    if (bus.dir) begin
      if (r_cnt == CNT_MAX) begin
        w_next    = SATURATE ? r_cnt : '0;
        w_wrapped = ~SATURATE;
      end else begin
        w_next = r_cnt + N'(1);
      end
    end else begin
      if (r_cnt == '0) begin
        w_next    = SATURATE ? r_cnt : CNT_MAX;
        w_wrapped = ~SATURATE;
      end else begin
        w_next = r_cnt - N'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p    <= '0;
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (bus.load) begin
      r_p    <= '0;
      r_cnt  <= bus.load_val;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_step) begin
      r_p    <= '0;
      r_cnt  <= w_next;
      r_tick <= 1'b1;
      r_wrap <= w_wrapped;
    end else begin
      if (bus.en) begin
        r_p <= r_p + PW'(1);
      end
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign bus.leds = bus.mode ? r_cnt : (r_cnt ^ (r_cnt >> 1));
  assign bus.tick = r_tick;
  assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_gray_counter_system_cfg.sv
// tb/tb_gray_counter_system_cfg.sv - directed bench for gray_counter_system_cfg
module tb_gray_counter_system_cfg;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  gray_counter_system_cfg_if #(.N(4)) ifa ();
  gray_counter_system_cfg_if #(.N(4)) ifb ();
  gray_counter_system_cfg_if #(.N(4)) ifc ();

  gray_counter_system_cfg #(.N(4), .DIVIDE(3), .SATURATE(1'b0)) u_dut_a (
    .i_clk(clk), .i_rst(rst_a), .bus(ifa)
  );
  gray_counter_system_cfg #(.N(4), .DIVIDE(3), .SATURATE(1'b1)) u_dut_b (
    .i_clk(clk), .i_rst(rst_b), .bus(ifb)
  );
  gray_counter_system_cfg #(.N(4), .DIVIDE(1), .SATURATE(1'b0)) u_dut_c (
    .i_clk(clk), .i_rst(rst_c), .bus(ifc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gray(input logic [3:0] c);
    return c ^ (c >> 1);
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Gray-mode tick on DUT A must change exactly one LED bit.
  logic [3:0] prev_leds = '0;
  logic       prev_mode = 1'b0;
  always @(negedge clk) begin
    if (!rst_a && ifa.tick && !ifa.mode && !prev_mode)
      check_eq("gray_1bit", 32'($countones(ifa.leds ^ prev_leds)), 32'd1);
    prev_leds = ifa.leds;
    prev_mode = ifa.mode;
  end

  initial begin
    ifa.en = 0; ifa.dir = 1; ifa.mode = 0; ifa.load = 0; ifa.load_val = '0;
    ifb.en = 0; ifb.dir = 1; ifb.mode = 0; ifb.load = 0; ifb.load_val = '0;
    ifc.en = 0; ifc.dir = 1; ifc.mode = 0; ifc.load = 0; ifc.load_val = '0;

    // 1: reset, then count up with wrap after 16 ticks
    step_clk();
    step_clk();
    check_eq("a_rst_leds", 32'(ifa.leds), 32'd0);
    check_eq("a_rst_tick", 32'(ifa.tick), 32'd0);
    check_eq("a_rst_wrap", 32'(ifa.wrap), 32'd0);
    rst_a = 0; ifa.en = 1; ifa.dir = 1; ifa.mode = 0;
    for (int k = 1; k <= 16; k++) begin
      step_clk(); check_eq("up_idle_tick", 32'(ifa.tick), 32'd0);
      step_clk(); check_eq("up_idle_tick", 32'(ifa.tick), 32'd0);
      step_clk();
      check_eq("up_tick", 32'(ifa.tick), 32'd1);
      check_eq("up_leds", 32'(ifa.leds), 32'(gray(4'(k % 16))));
      check_eq("up_wrap", 32'(ifa.wrap), (k == 16) ? 32'd1 : 32'd0);
    end

    // 2: load 0, count down through the wrap
    ifa.load = 1; ifa.load_val = 4'd0;
    step_clk();
    check_eq("ld0_tick", 32'(ifa.tick), 32'd0);
    check_eq("ld0_leds", 32'(ifa.leds), 32'd0);
    ifa.load = 0; ifa.dir = 0;
    step_clk(); step_clk();
    check_eq("dn_pre_tick", 32'(ifa.tick), 32'd0);
    step_clk();
    check_eq("dn_tick", 32'(ifa.tick), 32'd1);
    check_eq("dn_leds", 32'(ifa.leds), 32'b1000);
    check_eq("dn_wrap", 32'(ifa.wrap), 32'd1);
    ifa.mode = 1; #1;
    check_eq("dn_bin", 32'(ifa.leds), 32'd15);
    ifa.mode = 0;

    // 4: load collides with a due step
    ifa.dir = 1;
    step_clk(); check_eq("lv_idle", 32'(ifa.tick), 32'd0);
    step_clk(); check_eq("lv_idle", 32'(ifa.tick), 32'd0);
    ifa.load = 1; ifa.load_val = 4'd9;
    step_clk();
    check_eq("lv_tick", 32'(ifa.tick), 32'd0);
    check_eq("lv_leds", 32'(ifa.leds), 32'd13);
    ifa.load = 0;
    step_clk(); check_eq("lv_after1", 32'(ifa.tick), 32'd0);
    step_clk(); check_eq("lv_after2", 32'(ifa.tick), 32'd0);
    step_clk();
    check_eq("lv_tick3", 32'(ifa.tick), 32'd1);
    check_eq("lv_leds3", 32'(ifa.leds), 32'd15);

    // 5: en gap at p==1, then mode toggle
    step_clk();
    ifa.en = 0;
    for (int i = 0; i < 5; i++) begin
      step_clk();
      check_eq("gap_tick", 32'(ifa.tick), 32'd0);
      check_eq("gap_leds", 32'(ifa.leds), 32'd15);
    end
    ifa.en = 1;
    step_clk(); check_eq("res_tick1", 32'(ifa.tick), 32'd0);
    step_clk();
    check_eq("res_tick2", 32'(ifa.tick), 32'd1);
    check_eq("res_leds", 32'(ifa.leds), 32'd14);
    ifa.en = 0; ifa.mode = 1; #1;
    check_eq("mode_bin", 32'(ifa.leds), 32'd11);
    step_clk();
    check_eq("mode_hold", 32'(ifa.leds), 32'd11);
    ifa.mode = 0; #1;
    check_eq("mode_gray", 32'(ifa.leds), 32'd14);

    // 3: saturation at the top and bottom
    rst_b = 0; ifb.load = 1; ifb.load_val = 4'd14;
    step_clk();
    check_eq("sat_ld", 32'(ifb.leds), 32'd9);
    ifb.load = 0; ifb.en = 1; ifb.dir = 1; ifb.mode = 1;
    for (int k = 0; k < 4; k++) begin
      step_clk(); check_eq("satu_w", 32'(ifb.wrap), 32'd0);
      step_clk(); check_eq("satu_w", 32'(ifb.wrap), 32'd0);
      step_clk();
      check_eq("satu_tick", 32'(ifb.tick), 32'd1);
      check_eq("satu_cnt", 32'(ifb.leds), 32'd15);
      check_eq("satu_wrap", 32'(ifb.wrap), 32'd0);
    end
    ifb.load = 1; ifb.load_val = 4'd1;
    step_clk();
    check_eq("satd_ld", 32'(ifb.leds), 32'd1);
    ifb.load = 0; ifb.dir = 0;
    for (int k = 0; k < 3; k++) begin
      step_clk(); step_clk(); step_clk();
      check_eq("satd_tick", 32'(ifb.tick), 32'd1);
      check_eq("satd_cnt", 32'(ifb.leds), 32'd0);
      check_eq("satd_wrap", 32'(ifb.wrap), 32'd0);
    end

    // 6: DIVIDE=1, reset mid-run overrides load
    check_eq("c_rst_leds", 32'(ifc.leds), 32'd0);
    rst_c = 0; ifc.en = 1; ifc.dir = 1; ifc.mode = 0;
    for (int k = 1; k <= 5; k++) begin
      step_clk();
      check_eq("c_tick", 32'(ifc.tick), 32'd1);
      check_eq("c_leds", 32'(ifc.leds), 32'(gray(4'(k))));
    end
    rst_c = 1; ifc.load = 1; ifc.load_val = 4'd7;
    step_clk();
    check_eq("c_mrst_leds", 32'(ifc.leds), 32'd0);
    check_eq("c_mrst_tick", 32'(ifc.tick), 32'd0);
    check_eq("c_mrst_wrap", 32'(ifc.wrap), 32'd0);
    rst_c = 0; ifc.load = 0;
    for (int k = 1; k <= 17; k++) begin
      step_clk();
      check_eq("c2_tick", 32'(ifc.tick), 32'd1);
      check_eq("c2_leds", 32'(ifc.leds), 32'(gray(4'(k % 16))));
      check_eq("c2_wrap", 32'(ifc.wrap), (k == 16) ? 32'd1 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
